// File: rtl/traffic_pkg.sv
// Shared phase encoding for the N-approach traffic signal controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'b00,
        PH_GREEN   = 2'b01,
        PH_YELLOW  = 2'b10
    } phase_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk_50 down to a single-cycle tick every TICK_DIV cycles; TICK_DIV=1 ticks every cycle.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk_50,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_50) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/traffic_controller_n.sv
// Demand-actuated N-approach signal controller; define TRAFFIC_PREEMPT_EN to add preemption ports.
//   state      | meaning
//   PH_ALL_RED | clearance, every approach red; picks the next approach on exit
//   PH_GREEN   | active_idx has green, others red
//   PH_YELLOW  | active_idx has yellow, others red
module traffic_controller_n
    import traffic_pkg::*;
#(
    parameter int N_APPROACH = 4,
    parameter int TICK_DIV   = 50_000_000,
    parameter int MIN_GREEN  = 10,
    parameter int MAX_GREEN  = 30,
    parameter int YELLOW_T   = 3,
    parameter int ALL_RED_T  = 1,
    parameter int CNT_W      = 8
) (
    input  logic                          clk_50,
    input  logic                          reset,
    input  logic [N_APPROACH-1:0]         demand,
`ifdef TRAFFIC_PREEMPT_EN
    input  logic                          preempt,
    input  logic [$clog2(N_APPROACH)-1:0] preempt_idx,
`endif
    output logic [N_APPROACH-1:0]         red,
    output logic [N_APPROACH-1:0]         yellow,
    output logic [N_APPROACH-1:0]         green,
    output logic [$clog2(N_APPROACH)-1:0] active_idx,
    output logic [1:0]                    state
);

    localparam int               IW    = $clog2(N_APPROACH);
    localparam logic [CNT_W-1:0] MIN_G = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MAX_G = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] YEL_T = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] AR_T  = CNT_W'(ALL_RED_T);

    // First requesting approach after cur, wrapping back to cur; cur+1 if nobody asks.
    function automatic logic [IW-1:0] next_approach(input logic [N_APPROACH-1:0] dem,
                                                    input logic [IW-1:0]         cur);
        logic [IW-1:0] sel;
        logic          found;
        int            idx;
        sel   = IW'((int'(cur) + 1) % N_APPROACH);
        found = 1'b0;
        for (int k = 1; k <= N_APPROACH; k++) begin
            idx = (int'(cur) + k) % N_APPROACH;
            if (!found && dem[IW'(idx)]) begin
                sel   = IW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    logic                  tick;
    phase_t                state_q, state_d;
    logic [IW-1:0]         active_q, active_d, pick;
    logic [CNT_W-1:0]      timer_q, timer_d, elapsed;
    logic [N_APPROACH-1:0] red_q, red_d, yellow_q, yellow_d, green_q, green_d;
    logic [N_APPROACH-1:0] own_mask;
    logic                  other, own, hold_grn, force_exit;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk_50 (clk_50),
        .reset  (reset),
        .tick   (tick)
    );

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        timer_d    = timer_q;
        red_d      = '1;
        yellow_d   = '0;
        green_d    = '0;
        own_mask   = '0;
        own_mask[active_q] = 1'b1;
        other      = |(demand & ~own_mask);
        own        = demand[active_q];
        elapsed    = (timer_q >= MAX_G) ? MAX_G : timer_q + 1'b1;
        hold_grn   = 1'b0;
        force_exit = 1'b0;
        pick       = next_approach(demand, active_q);
`ifdef TRAFFIC_PREEMPT_EN
        if (preempt) begin
            hold_grn   = (active_q == preempt_idx);
            force_exit = !hold_grn;
            pick       = preempt_idx;
        end
`endif
        if (tick) begin
            timer_d = elapsed;
            unique case (state_q)
                PH_GREEN: begin
                    if (!hold_grn && (force_exit ||
                        (elapsed >= MIN_G && other && (!own || elapsed >= MAX_G)))) begin
                        state_d = PH_YELLOW;
                        timer_d = '0;
                    end
                end
                PH_YELLOW: begin
                    if (elapsed == YEL_T) begin
                        state_d = PH_ALL_RED;
                        timer_d = '0;
                    end
                end
                PH_ALL_RED: begin
                    if (elapsed == AR_T) begin
                        state_d  = PH_GREEN;
                        active_d = pick;
                        timer_d  = '0;
                    end
                end
                default: begin
                    state_d = PH_ALL_RED;
                    timer_d = '0;
                end
            endcase
        end
        // Lamps are registered from the next phase so they line up with state.
        if (state_d != PH_ALL_RED) red_d[active_d]    = 1'b0;
        if (state_d == PH_GREEN)   green_d[active_d]  = 1'b1;
        if (state_d == PH_YELLOW)  yellow_d[active_d] = 1'b1;
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q  <= PH_ALL_RED;
            active_q <= IW'(N_APPROACH - 1);
            timer_q  <= '0;
            red_q    <= '1;
            yellow_q <= '0;
            green_q  <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            timer_q  <= timer_d;
            red_q    <= red_d;
            yellow_q <= yellow_d;
            green_q  <= green_d;
        end
    end

    assign red        = red_q;
    assign yellow     = yellow_q;
    assign green      = green_q;
    assign active_idx = active_q;
    assign state      = state_q;

endmodule

// File: tb/tb_traffic_controller_n.sv
// Self-checking bench for traffic_controller_n: directed phase-sequence scenarios plus a randomized run against a tick-level model.
module tb_traffic_controller_n;

    localparam int N    = 4;
    localparam int TD   = 4;
    localparam int MING = 2;
    localparam int MAXG = 4;
    localparam int YT   = 2;
    localparam int ART  = 1;

    logic         clk_50 = 1'b0;
    logic         reset;
    logic [N-1:0] demand;
    logic [N-1:0] red, yellow, green;
    logic [1:0]   active_idx;
    logic [1:0]   state;
`ifdef TRAFFIC_PREEMPT_EN
    logic         preempt;
    logic [1:0]   preempt_idx;
`endif

    logic [15:0] obs;
    assign obs = {state, active_idx, red, yellow, green};

    int n_cmp = 0;
    int n_bad = 0;

    // model: phase 0=all-red 1=green 2=yellow, ticks spent in phase, prescaler count
    int m_phase, m_act, m_t, m_pre;

    traffic_controller_n #(
        .N_APPROACH(N), .TICK_DIV(TD), .MIN_GREEN(MING), .MAX_GREEN(MAXG),
        .YELLOW_T(YT), .ALL_RED_T(ART), .CNT_W(8)
    ) dut (
        .clk_50     (clk_50),
        .reset      (reset),
        .demand     (demand),
`ifdef TRAFFIC_PREEMPT_EN
        .preempt    (preempt),
        .preempt_idx(preempt_idx),
`endif
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .active_idx (active_idx),
        .state      (state)
    );

    always #5 clk_50 = ~clk_50;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void model_step(input bit rst, input logic [N-1:0] dem);
        int  e;
        bool_search: begin end
        if (rst) begin
            m_phase = 0; m_act = N - 1; m_t = 0; m_pre = 0;
            return;
        end
        if (m_pre != TD - 1) begin
            m_pre = m_pre + 1;
            return;
        end
        m_pre = 0;
        e = (m_t + 1 > MAXG) ? MAXG : m_t + 1;
        m_t = e;
        if (m_phase == 1) begin
            logic [N-1:0] others;
            others = dem;
            others[m_act] = 1'b0;
            if (e >= MING && others != 0 && (!dem[m_act] || e >= MAXG)) begin
                m_phase = 2; m_t = 0;
            end
        end else if (m_phase == 2) begin
            if (e == YT) begin m_phase = 0; m_t = 0; end
        end else begin
            if (e == ART) begin
                int nxt;
                nxt = (m_act + 1) % N;
                for (int k = N; k >= 1; k--)
                    if (dem[(m_act + k) % N]) nxt = (m_act + k) % N;
                m_act = nxt; m_phase = 1; m_t = 0;
            end
        end
    endfunction

    function automatic logic [15:0] model_vec();
        logic [N-1:0] r, y, g;
        r = '1; y = '0; g = '0;
        if (m_phase != 0) r[m_act] = 1'b0;
        if (m_phase == 1) g[m_act] = 1'b1;
        if (m_phase == 2) y[m_act] = 1'b1;
        return {2'(m_phase), 2'(m_act), r, y, g};
    endfunction

    task automatic hold_len(output int n);
        logic [15:0] snap;
        bit          done;
        snap = obs; n = 1; done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(posedge clk_50); #1;
            if (obs === snap) n++;
            else done = 1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        demand = '0;
`ifdef TRAFFIC_PREEMPT_EN
        preempt = 1'b0; preempt_idx = '0;
`endif
        repeat (2) begin @(posedge clk_50); #1; end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int n, bad_rest;
        reset = 1'b1; demand = '0;
`ifdef TRAFFIC_PREEMPT_EN
        preempt = 1'b0; preempt_idx = '0;
`endif
        repeat (3) begin @(posedge clk_50); #1; end
        n_cmp++; if (red !== 4'b1111) begin n_bad++; $display("FAIL reset_red got %b want 1111", red); end
        n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL reset_state got %b want 00", state); end
        n_cmp++; if (active_idx !== 2'd3) begin n_bad++; $display("FAIL reset_active got %0d want 3", active_idx); end
        reset = 1'b0;
        hold_len(n);
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL first_tick got %0d cycles want 4", n); end
        n_cmp++; if ({state, green} !== {2'b01, 4'b0001}) begin
            n_bad++; $display("FAIL first_green got state %b green %b want 01 0001", state, green); end
        bad_rest = 0;
        repeat (100 * TD) begin
            @(posedge clk_50); #1;
            if (green !== 4'b0001 || state !== 2'b01) bad_rest++;
        end
        n_cmp++; if (bad_rest !== 0) begin n_bad++; $display("FAIL rest_green got %0d bad cycles want 0", bad_rest); end
    endtask

    task automatic test_gap_out();
        int n;
        do_reset();
        hold_len(n);
        demand = 4'b0100;
        hold_len(n);
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL gap_green_len got %0d want 8", n); end
        n_cmp++; if ({state, yellow} !== {2'b10, 4'b0001}) begin
            n_bad++; $display("FAIL gap_yellow got state %b yellow %b want 10 0001", state, yellow); end
        hold_len(n);
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL gap_yellow_len got %0d want 8", n); end
        n_cmp++; if ({state, red} !== {2'b00, 4'b1111}) begin
            n_bad++; $display("FAIL gap_allred got state %b red %b want 00 1111", state, red); end
        hold_len(n);
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL gap_allred_len got %0d want 4", n); end
        n_cmp++; if ({state, green} !== {2'b01, 4'b0100}) begin
            n_bad++; $display("FAIL gap_next_green got state %b green %b want 01 0100", state, green); end
    endtask

    task automatic test_max_out_skip_wrap();
        int n;
        do_reset();
        hold_len(n);
        demand = 4'b1001;
        hold_len(n);
        n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL max_green_len got %0d want 16", n); end
        n_cmp++; if ({state, yellow} !== {2'b10, 4'b0001}) begin
            n_bad++; $display("FAIL max_yellow got state %b yellow %b want 10 0001", state, yellow); end
        hold_len(n);
        hold_len(n);
        n_cmp++; if ({state, green, active_idx} !== {2'b01, 4'b1000, 2'd3}) begin
            n_bad++; $display("FAIL skip_green got state %b green %b idx %0d want 01 1000 3", state, green, active_idx); end
        hold_len(n);
        n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL max3_green_len got %0d want 16", n); end
        demand = 4'b0010;
        hold_len(n);
        n_cmp++; if ({state, active_idx} !== {2'b00, 2'd3}) begin
            n_bad++; $display("FAIL wrap_allred got state %b idx %0d want 00 3", state, active_idx); end
        hold_len(n);
        n_cmp++; if ({state, green, active_idx} !== {2'b01, 4'b0010, 2'd1}) begin
            n_bad++; $display("FAIL wrap_green got state %b green %b idx %0d want 01 0010 1", state, green, active_idx); end
    endtask

    task automatic test_reset_mid_yellow();
        int n;
        do_reset();
        hold_len(n);
        demand = 4'b0010;
        hold_len(n);
        repeat (2) begin @(posedge clk_50); #1; end
        n_cmp++; if (state !== 2'b10) begin n_bad++; $display("FAIL midy_pre got state %b want 10", state); end
        reset = 1'b1;
        @(posedge clk_50); #1;
        n_cmp++; if (obs !== {2'b00, 2'd3, 4'b1111, 4'b0000, 4'b0000}) begin
            n_bad++; $display("FAIL midy_reset got %h want %h", obs, {2'b00, 2'd3, 4'b1111, 8'h00}); end
        reset = 1'b0;
        hold_len(n);
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL midy_prescaler got %0d want 4", n); end
        n_cmp++; if (green !== 4'b0010) begin n_bad++; $display("FAIL midy_green got %b want 0010", green); end
    endtask

`ifdef TRAFFIC_PREEMPT_EN
    task automatic test_preempt();
        int n, bad_hold;
        do_reset();
        demand = 4'b0010;
        hold_len(n);
        n_cmp++; if (green !== 4'b0010) begin n_bad++; $display("FAIL pre_start got %b want 0010", green); end
        preempt = 1'b1; preempt_idx = 2'd2;
        hold_len(n);
        n_cmp++; if (n !== 4 || yellow !== 4'b0010) begin
            n_bad++; $display("FAIL pre_exit got len %0d yellow %b want 4 0010", n, yellow); end
        hold_len(n);
        hold_len(n);
        n_cmp++; if (green !== 4'b0100) begin n_bad++; $display("FAIL pre_green got %b want 0100", green); end
        demand = 4'b1011;
        bad_hold = 0;
        repeat (10 * TD) begin
            @(posedge clk_50); #1;
            if (green !== 4'b0100) bad_hold++;
        end
        n_cmp++; if (bad_hold !== 0) begin n_bad++; $display("FAIL pre_hold got %0d bad cycles want 0", bad_hold); end
        preempt = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [15:0] exp_v;
        for (int c = 0; c < 3000; c++) begin
            reset = (c < 2) || ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 5) == 0)
                demand = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            model_step(reset, demand);
            @(posedge clk_50); #1;
            exp_v = model_vec();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL random cyc %0d got %h want %h", c, obs, exp_v);
            end
            n_cmp++;
            if (!$onehot0(green | yellow) || (red | yellow | green) !== 4'b1111 ||
                (red & yellow) !== 4'b0 || (red & green) !== 4'b0) begin
                n_bad++; $display("FAIL lamp_safety cyc %0d got r %b y %b g %b", c, red, yellow, green);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        demand = '0;
`ifdef TRAFFIC_PREEMPT_EN
        preempt = 1'b0; preempt_idx = '0;
`endif
        test_reset();
        test_gap_out();
        test_max_out_skip_wrap();
        test_reset_mid_yellow();
`ifdef TRAFFIC_PREEMPT_EN
        test_preempt();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
